bsg_fifo_ptr_tracker: RTL and testbench

Occupancy controller for a 1-write/1-read circular FIFO. It sequences two `bsg_circular_ptr` instances, one for writes and one for reads, and tracks EMPTY/PARTIAL/FULL state, element count and a valid/ready handshake toward producer and consumer. It sits beside a 1R1W RAM (sync- or async-read) and supplies its addresses, so FIFO RAM wrappers need no pointer logic of their own.

---
 rtl/bsg_fifo_ptr_tracker_pkg.sv | 11 +
 rtl/bsg_circular_ptr.sv | 38 +++
 rtl/bsg_fifo_ptr_tracker.sv | 91 +++++++++
 tb/tb_bsg_fifo_ptr_tracker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/bsg_fifo_ptr_tracker_pkg.sv
// Types shared by the FIFO occupancy trackers.
// Later multi-port trackers reuse the state encoding declared here.
package bsg_fifo_tracker_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } bsg_fifo_tracker_state_e;

endpackage

// File: rtl/bsg_circular_ptr.sv
// Modulo-slots_p pointer that advances by add_i each cycle.
// n_o is the combinational next value; it reads 0 while reset_i is high.
module bsg_circular_ptr #(
  parameter  int slots_p      = 16,
  parameter  int max_add_p    = 1,
  localparam int ptr_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1,
  localparam int add_width_lp = $clog2(max_add_p + 1)
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [add_width_lp-1:0] add_i,
  output logic [ptr_width_lp-1:0] o,
  output logic [ptr_width_lp-1:0] n_o
);

  logic [ptr_width_lp-1:0] ptr_q, ptr_d;
  logic [ptr_width_lp:0]   sum;

  // One subtraction suffices because max_add_p stays below slots_p.
  always_comb begin
    sum = {1'b0, ptr_q} + (ptr_width_lp + 1)'(add_i);
    if (reset_i) begin
      ptr_d = '0;
    end else if (sum >= (ptr_width_lp + 1)'(slots_p)) begin
      ptr_d = ptr_width_lp'(sum - (ptr_width_lp + 1)'(slots_p));
    end else begin
      ptr_d = ptr_width_lp'(sum);
    end
  end

  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign o   = ptr_q;
  assign n_o = ptr_d;

endmodule

// File: rtl/bsg_fifo_ptr_tracker.sv
// Occupancy controller for a 1R1W circular FIFO: supplies RAM addresses,
// count, empty/full and the producer/consumer handshake.
module bsg_fifo_ptr_tracker
  import bsg_fifo_tracker_pkg::*;
#(
  parameter  int els_p          = 16,
  localparam int ptr_width_lp   = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [ptr_width_lp-1:0]   wptr_r_o,
  output logic [ptr_width_lp-1:0]   rptr_r_o,
  output logic [ptr_width_lp-1:0]   rptr_n_o,
  output logic [count_width_lp-1:0] count_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      err_o
);

  localparam logic [count_width_lp-1:0] almost_full_lp = count_width_lp'(els_p - 1);
  localparam logic [count_width_lp-1:0] one_lp         = count_width_lp'(1);

  bsg_fifo_tracker_state_e    state_q, state_d;
  logic [count_width_lp-1:0]  count_q, count_d;
  logic                       err_q, err_d;
  logic                       enq, deq;

  assign ready_o = (state_q != FULL);
  assign v_o     = (state_q != EMPTY);
  assign empty_o = (state_q == EMPTY);
  assign full_o  = (state_q == FULL);
  assign count_o = count_q;
  assign err_o   = err_q;

  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  bsg_circular_ptr #(
    .slots_p  (els_p),
    .max_add_p(1)
  ) wptr (
    .clk    (clk),
    .reset_i(reset_i),
    .add_i  (enq),
    .o      (wptr_r_o),
    .n_o    ()
  );

  bsg_circular_ptr #(
    .slots_p  (els_p),
    .max_add_p(1)
  ) rptr (
    .clk    (clk),
    .reset_i(reset_i),
    .add_i  (deq),
    .o      (rptr_r_o),
    .n_o    (rptr_n_o)
  );

  // Pointers alone cannot tell full from empty; state_q resolves that.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q | (yumi_i & ~v_o);
    if (enq & ~deq) begin
      count_d = count_q + one_lp;
      state_d = (count_q == almost_full_lp) ? FULL : PARTIAL;
    end else if (deq & ~enq) begin
      count_d = count_q - one_lp;
      state_d = (count_q == one_lp) ? EMPTY : PARTIAL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= EMPTY;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_bsg_fifo_ptr_tracker.sv
// Scoreboard bench for two trackers (depth 16 and depth 5) driven side by side
// against an occupancy model built from enqueue/dequeue totals.
module tb_bsg_fifo_ptr_tracker;

  localparam int E0 = 16;
  localparam int E1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_i;
  logic       v_i0, yumi_i0, v_i1, yumi_i1;
  logic       ready0, vo0, empty0, full0, err0;
  logic       ready1, vo1, empty1, full1, err1;
  logic [3:0] wptr0, rptr0, rptrn0;
  logic [4:0] count0;
  logic [2:0] wptr1, rptr1, rptrn1;
  logic [2:0] count1;

  bsg_fifo_ptr_tracker #(.els_p(E0)) dut0 (
    .clk(clk), .reset_i(reset_i), .v_i(v_i0), .ready_o(ready0), .v_o(vo0),
    .yumi_i(yumi_i0), .wptr_r_o(wptr0), .rptr_r_o(rptr0), .rptr_n_o(rptrn0),
    .count_o(count0), .empty_o(empty0), .full_o(full0), .err_o(err0)
  );

  bsg_fifo_ptr_tracker #(.els_p(E1)) dut1 (
    .clk(clk), .reset_i(reset_i), .v_i(v_i1), .ready_o(ready1), .v_o(vo1),
    .yumi_i(yumi_i1), .wptr_r_o(wptr1), .rptr_r_o(rptr1), .rptr_n_o(rptrn1),
    .count_o(count1), .empty_o(empty1), .full_o(full1), .err_o(err1)
  );

  typedef struct {
    int inst;
    int cnt;
    int wp;
    int rp;
    bit err;
  } st_t;

  typedef struct {
    int inst;
    int rpn;
  } cb_t;

  st_t sb_st[$];
  cb_t sb_cb[$];

  int n_cmp = 0;
  int n_err = 0;

  int nenq[2];
  int ndeq[2];
  bit merr[2];
  int els[2];

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] @%0t: got %0d expected %0d", nm, inst, $time, act, exp);
    end
  endtask

  function automatic bit have(input int i);
    return nenq[i] > ndeq[i];
  endfunction

  // Expected values come only from the totals of accepted operations.
  task automatic model_step(input int i, input bit v, input bit y, input bit rst);
    int  c;
    st_t s;
    cb_t b;
    c = nenq[i] - ndeq[i];
    b.inst = i;
    b.rpn  = rst ? 0 : (ndeq[i] + ((y && c > 0) ? 1 : 0)) % els[i];
    sb_cb.push_back(b);
    if (rst) begin
      nenq[i] = 0;
      ndeq[i] = 0;
      merr[i] = 1'b0;
    end else begin
      if (y && c == 0) merr[i] = 1'b1;
      if (v && c < els[i]) nenq[i]++;
      if (y && c > 0) ndeq[i]++;
    end
    s.inst = i;
    s.cnt  = nenq[i] - ndeq[i];
    s.wp   = nenq[i] % els[i];
    s.rp   = ndeq[i] % els[i];
    s.err  = merr[i];
    sb_st.push_back(s);
  endtask

  task automatic step(input bit v0, input bit y0, input bit v1, input bit y1, input bit rst);
    @(negedge clk);
    reset_i = rst;
    v_i0    = v0;
    yumi_i0 = y0;
    v_i1    = v1;
    yumi_i1 = y1;
    model_step(0, v0, y0, rst);
    model_step(1, v1, y1, rst);
  endtask

  always @(posedge clk) begin
    st_t e;
    #1;
    while (sb_st.size() > 0) begin
      e = sb_st.pop_front();
      if (e.inst == 0) begin
        chk("count", 0, 32'(count0), e.cnt);
        chk("wptr", 0, 32'(wptr0), e.wp);
        chk("rptr", 0, 32'(rptr0), e.rp);
        chk("empty", 0, 32'(empty0), (e.cnt == 0) ? 1 : 0);
        chk("full", 0, 32'(full0), (e.cnt == E0) ? 1 : 0);
        chk("ready", 0, 32'(ready0), (e.cnt < E0) ? 1 : 0);
        chk("v_o", 0, 32'(vo0), (e.cnt > 0) ? 1 : 0);
        chk("err", 0, 32'(err0), 32'(e.err));
      end else begin
        chk("count", 1, 32'(count1), e.cnt);
        chk("wptr", 1, 32'(wptr1), e.wp);
        chk("rptr", 1, 32'(rptr1), e.rp);
        chk("empty", 1, 32'(empty1), (e.cnt == 0) ? 1 : 0);
        chk("full", 1, 32'(full1), (e.cnt == E1) ? 1 : 0);
        chk("ready", 1, 32'(ready1), (e.cnt < E1) ? 1 : 0);
        chk("v_o", 1, 32'(vo1), (e.cnt > 0) ? 1 : 0);
        chk("err", 1, 32'(err1), 32'(e.err));
      end
    end
  end

  always @(negedge clk) begin
    cb_t b;
    #2;
    while (sb_cb.size() > 0) begin
      b = sb_cb.pop_front();
      if (b.inst == 0) chk("rptr_n", 0, 32'(rptrn0), b.rpn);
      else             chk("rptr_n", 1, 32'(rptrn1), b.rpn);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    els[0] = E0;
    els[1] = E1;
    for (int i = 0; i < 2; i++) begin
      nenq[i] = 0;
      ndeq[i] = 0;
      merr[i] = 1'b0;
    end
    reset_i = 1'b1;
    v_i0 = 1'b0; yumi_i0 = 1'b0; v_i1 = 1'b0; yumi_i1 = 1'b0;

    // reset held two cycles with both strobes high
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);

    // fill past full; the extra offers must be ignored
    for (int k = 0; k < 17; k++) step(1, 0, 1, 0, 0);
    // both strobes while full: only the dequeue happens
    step(1, 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) step(0, have(0), 0, have(1), 0);

    // enqueue 3 / dequeue 3, four rounds, to walk the pointers round the wrap
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 0);
    end

    // count 7 then simultaneous traffic
    for (int k = 0; k < 7; k++) step(1, 0, 1, 0, 0);
    for (int k = 0; k < 10; k++) step(1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 1);

    // random legal traffic
    for (int k = 0; k < 1500; k++) begin
      bit v0, v1, y0, y1;
      v0 = ($urandom_range(0, 9) < 6);
      v1 = ($urandom_range(0, 9) < 5);
      y0 = ($urandom_range(0, 9) < 5) && have(0);
      y1 = ($urandom_range(0, 9) < 6) && have(1);
      step(v0, y0, v1, y1, 0);
    end

    // reset in the middle of operation with an offer pending
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 9; k++) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    // underflow: err is sticky until reset
    step(0, 1, 0, 1, 0);
    for (int k = 0; k < 20; k++) begin
      bit v0, y0;
      v0 = $urandom_range(0, 1) == 1;
      y0 = ($urandom_range(0, 1) == 1) && have(0);
      step(v0, y0, v0, y0 && have(1), 0);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    #3;
    n_cmp++;
    if (sb_st.size() != 0 || sb_cb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", sb_st.size(), sb_cb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
